// File: rtl/ctrlunit_decoder.sv
// RV32I control decoder: combinational control-signal generation from the
// instruction word and branch-compare results, plus a sticky illegal-instruction flag.
module ctrlunit_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        breq,
  input  logic        brlt,
  output logic        pcsel,
  output logic [4:0]  immsel,
  output logic        brun,
  output logic        asel,
  output logic        bsel,
  output logic [3:0]  op,
  output logic        wren,
  output logic        regwen,
  output logic [1:0]  wbsel,
  output logic [2:0]  rwsel,
  output logic        ill,
  output logic        illflag
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_I_ALU  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b00001;
  localparam logic [4:0] IMM_S    = 5'b00010;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_U    = 5'b01000;
  localparam logic [4:0] IMM_J    = 5'b10000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  logic [4:0] opcode;
  logic [2:0] f3;
  logic       b30;
  logic       br_taken;
  logic       unused_bits;

  assign opcode = instr[6:2];
  assign f3     = instr[14:12];
  assign b30    = instr[30];

  // Bits the decoder deliberately does not look at.
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], instr[1:0]};

  always_comb begin
    ill = 1'b0;
    case (opcode)
      OPC_R:      ill = b30 && !((f3 == 3'b000) || (f3 == 3'b101));
      OPC_I_ALU:  ill = b30 && (f3 == 3'b001);
      OPC_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OPC_STORE:  ill = (f3 > 3'b010);
      OPC_BRANCH: ill = (f3[2:1] == 2'b01);
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ill = 1'b0;
      default:    ill = 1'b1;
    endcase
  end

  // brlt already reflects signed/unsigned selection via brun, so f3[1] only matters there.
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:         br_taken = breq;
      3'b001:         br_taken = ~breq;
      3'b100, 3'b110: br_taken = brlt;
      3'b101, 3'b111: br_taken = ~brlt;
      default:        br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pcsel  = 1'b0;
    immsel = IMM_NONE;
    asel   = 1'b0;
    bsel   = 1'b0;
    op     = ALU_ADD;
    wren   = 1'b0;
    regwen = 1'b0;
    wbsel  = WB_MEM;
    rwsel  = f3;
    brun   = f3[1];
    if (!ill) begin
      case (opcode)
        OPC_R: begin
          op     = {b30, f3};
          regwen = 1'b1;
          wbsel  = WB_ALU;
        end
        OPC_I_ALU: begin
          immsel = IMM_I;
          bsel   = 1'b1;
          // Only shift-right uses b30 as a funct bit; elsewhere it is immediate data.
          op     = {(f3 == 3'b101) ? b30 : 1'b0, f3};
          regwen = 1'b1;
          wbsel  = WB_ALU;
        end
        OPC_LOAD: begin
          immsel = IMM_I;
          bsel   = 1'b1;
          regwen = 1'b1;
          wbsel  = WB_MEM;
        end
        OPC_STORE: begin
          immsel = IMM_S;
          bsel   = 1'b1;
          wren   = 1'b1;
        end
        OPC_BRANCH: begin
          pcsel  = br_taken;
          immsel = IMM_B;
          asel   = 1'b1;
          bsel   = 1'b1;
        end
        OPC_JAL: begin
          pcsel  = 1'b1;
          immsel = IMM_J;
          asel   = 1'b1;
          bsel   = 1'b1;
          regwen = 1'b1;
          wbsel  = WB_PC4;
        end
        OPC_JALR: begin
          pcsel  = 1'b1;
          immsel = IMM_I;
          bsel   = 1'b1;
          regwen = 1'b1;
          wbsel  = WB_PC4;
        end
        OPC_LUI: begin
          immsel = IMM_U;
          bsel   = 1'b1;
          op     = ALU_PASSB;
          regwen = 1'b1;
          wbsel  = WB_ALU;
        end
        OPC_AUIPC: begin
          immsel = IMM_U;
          asel   = 1'b1;
          bsel   = 1'b1;
          regwen = 1'b1;
          wbsel  = WB_ALU;
        end
        default: begin
          pcsel = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illflag <= 1'b0;
    end else if (ill) begin
      illflag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrlunit_decoder.sv
// Directed bench for ctrlunit_decoder: table of decode vectors checked through an
// expected queue, followed by hand-written sequences for the sticky illegal flag.
module tb_ctrlunit_decoder;

  localparam int W = 21;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        breq;
  logic        brlt;
  logic        pcsel;
  logic [4:0]  immsel;
  logic        brun;
  logic        asel;
  logic        bsel;
  logic [3:0]  op;
  logic        wren;
  logic        regwen;
  logic [1:0]  wbsel;
  logic [2:0]  rwsel;
  logic        ill;
  logic        illflag;

  typedef struct {
    string         name;
    logic [31:0]   instr;
    logic          breq;
    logic          brlt;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_pass;

  ctrlunit_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .breq    (breq),
    .brlt    (brlt),
    .pcsel   (pcsel),
    .immsel  (immsel),
    .brun    (brun),
    .asel    (asel),
    .bsel    (bsel),
    .op      (op),
    .wren    (wren),
    .regwen  (regwen),
    .wbsel   (wbsel),
    .rwsel   (rwsel),
    .ill     (ill),
    .illflag (illflag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pcsel immsel brun asel bsel op wren regwen wbsel rwsel ill
  function automatic logic [W-1:0] e(input logic pc, input logic [4:0] imm, input logic bu,
                                     input logic a, input logic b, input logic [3:0] o,
                                     input logic we, input logic rw, input logic [1:0] wb,
                                     input logic [2:0] rs, input logic il);
    return {pc, imm, bu, a, b, o, we, rw, wb, rs, il};
  endfunction

  function automatic logic [W-1:0] e_ill(input logic [2:0] rs);
    return e(1'b0, 5'b00000, rs[1], 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b00, rs, 1'b1);
  endfunction

  task automatic add_vec(input string name, input logic [31:0] i, input logic eq,
                         input logic lt, input logic [W-1:0] x);
    vec_t v;
    v.name = name; v.instr = i; v.breq = eq; v.brlt = lt; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask

  // Driver
  task automatic drive(input logic [31:0] i, input logic eq, input logic lt);
    instr = i;
    breq  = eq;
    brlt  = lt;
  endtask

  // Scoreboard
  task automatic check_outputs(input string name);
    logic [W-1:0] act;
    logic [W-1:0] req;
    act = {pcsel, immsel, brun, asel, bsel, op, wren, regwen, wbsel, rwsel, ill};
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard queue empty, got %b", name, act);
      return;
    end
    req = exp_q.pop_front();
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b, expected %b (pc imm bu a b op we rw wb rs il)",
                  name, act, req);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    drive(32'h0000_0013, 1'b0, 1'b0);

    add_vec("sub",        32'h4000_0033, 0, 0, e(0, 5'b00000, 0, 0, 0, 4'b1000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("add",        32'h0000_0033, 0, 0, e(0, 5'b00000, 0, 0, 0, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("sra",        32'h4000_5033, 0, 0, e(0, 5'b00000, 0, 0, 0, 4'b1101, 0, 1, 2'b01, 3'b101, 0));
    add_vec("sltu",       32'h0000_3033, 0, 0, e(0, 5'b00000, 1, 0, 0, 4'b0011, 0, 1, 2'b01, 3'b011, 0));
    add_vec("r_b30_ill",  32'h4000_1033, 0, 0, e_ill(3'b001));
    add_vec("add_lo00",   32'h0000_0030, 0, 0, e(0, 5'b00000, 0, 0, 0, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("add_b31",    32'h8000_0033, 0, 0, e(0, 5'b00000, 0, 0, 0, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("srai",       32'h4000_5013, 0, 0, e(0, 5'b00001, 0, 0, 1, 4'b1101, 0, 1, 2'b01, 3'b101, 0));
    add_vec("slli_b30",   32'h4000_1013, 0, 0, e_ill(3'b001));
    add_vec("addi_b30",   32'h4000_0013, 0, 0, e(0, 5'b00001, 0, 0, 1, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("xori",       32'h0000_4013, 0, 0, e(0, 5'b00001, 0, 0, 1, 4'b0100, 0, 1, 2'b01, 3'b100, 0));
    add_vec("lhu",        32'h0000_5003, 0, 0, e(0, 5'b00001, 0, 0, 1, 4'b0000, 0, 1, 2'b00, 3'b101, 0));
    add_vec("load_f3_3",  32'h0000_3003, 0, 0, e_ill(3'b011));
    add_vec("load_f3_6",  32'h0000_6003, 0, 0, e_ill(3'b110));
    add_vec("sw",         32'h0000_2023, 0, 0, e(0, 5'b00010, 1, 0, 1, 4'b0000, 1, 0, 2'b00, 3'b010, 0));
    add_vec("store_f3_3", 32'h0000_3023, 0, 0, e_ill(3'b011));
    add_vec("beq_t",      32'h0000_0063, 1, 0, e(1, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b000, 0));
    add_vec("beq_nt",     32'h0000_0063, 0, 1, e(0, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b000, 0));
    add_vec("bne_eq",     32'h0000_1063, 1, 0, e(0, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b001, 0));
    add_vec("bne_ne",     32'h0000_1063, 0, 0, e(1, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b001, 0));
    add_vec("blt_lt",     32'h0000_4063, 0, 1, e(1, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b100, 0));
    add_vec("bge_lt",     32'h0000_5063, 0, 1, e(0, 5'b00100, 0, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b101, 0));
    add_vec("bltu_lt",    32'h0000_6063, 0, 1, e(1, 5'b00100, 1, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b110, 0));
    add_vec("bgeu_ge",    32'h0000_7063, 0, 0, e(1, 5'b00100, 1, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b111, 0));
    add_vec("bgeu_lt",    32'h0000_7063, 0, 1, e(0, 5'b00100, 1, 1, 1, 4'b0000, 0, 0, 2'b00, 3'b111, 0));
    add_vec("br_f3_2",    32'h0000_2063, 1, 1, e_ill(3'b010));
    add_vec("jal",        32'h0000_006F, 0, 0, e(1, 5'b10000, 0, 1, 1, 4'b0000, 0, 1, 2'b10, 3'b000, 0));
    add_vec("jalr_f3_7",  32'h0000_7067, 0, 0, e(1, 5'b00001, 1, 0, 1, 4'b0000, 0, 1, 2'b10, 3'b111, 0));
    add_vec("lui",        32'h0000_0037, 0, 0, e(0, 5'b01000, 0, 0, 1, 4'b1001, 0, 1, 2'b01, 3'b000, 0));
    add_vec("auipc",      32'h0000_0017, 0, 0, e(0, 5'b01000, 0, 1, 1, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    add_vec("opc_1f",     32'h0000_007F, 0, 0, e_ill(3'b000));
    add_vec("opc_02",     32'h0000_400B, 0, 0, e_ill(3'b100));

    // Reset state and rst independence of the combinational outputs
    #1;
    check_bit("illflag_reset", illflag, 1'b0);
    exp_q.push_back(e(0, 5'b00001, 0, 0, 1, 4'b0000, 0, 1, 2'b01, 3'b000, 0));
    check_outputs("addi_in_reset");

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].instr, vecs[k].breq, vecs[k].brlt);
      exp_q.push_back(vecs[k].exp);
      #1;
      check_outputs(vecs[k].name);
    end

    // Legal stream after reset leaves the flag clear
    @(negedge clk);
    rst = 1'b1;
    drive(32'h0000_0033, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("illflag_legal_stream", illflag, 1'b0);

    // Illegal opcode: flag only rises on the clock edge
    @(negedge clk);
    drive(32'h0000_007F, 1'b0, 1'b0);
    #1;
    check_bit("ill_comb_7f", ill, 1'b1);
    check_bit("illflag_before_edge", illflag, 1'b0);
    @(posedge clk);
    #1;
    check_bit("illflag_after_edge", illflag, 1'b1);

    // Sticky across legal instructions
    @(negedge clk);
    drive(32'h0000_006F, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_bit("illflag_sticky", illflag, 1'b1);

    // Asynchronous clear mid-cycle, before the next rising edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_bit("illflag_async_clr", illflag, 1'b0);

    // Held in reset, an illegal instruction must not set the flag
    drive(32'h0000_007F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_bit("illflag_held_rst", illflag, 1'b0);
    check_bit("ill_during_rst", ill, 1'b1);

    @(negedge clk);
    rst = 1'b0;
    drive(32'h0000_0037, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_bit("illflag_after_release", illflag, 1'b0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrlunit_decoder.md
CTRLUNIT_DECODER -- requirements
Module: ctrlunit

Interface
REQ-001 SHALL have these ports: clk input 1, rising-edge clock, used only by the sticky illegal flag.
REQ-002 SHALL have these ports: rst input 1, asynchronous active-high reset.
REQ-003 SHALL have these ports: instr input 32, RV32I instruction word.
REQ-004 SHALL have these ports: breq input 1, rs1==rs2 from the branch comparator.
REQ-005 SHALL have these ports: brlt input 1, rs1<rs2 from the branch comparator, signed or unsigned per brun.
REQ-006 SHALL have these ports: pcsel output 1; 1 = next PC from ALU, 0 = PC+4.
REQ-007 SHALL have these ports: immsel output 5, one-hot immediate format: I=00001, S=00010, B=00100, U=01000, J=10000.
REQ-008 SHALL have these ports: brun output 1, unsigned branch compare.
REQ-009 SHALL have these ports: asel output 1; ALU A = PC when 1, rs1 when 0.
REQ-010 SHALL have these ports: bsel output 1; ALU B = imm when 1, rs2 when 0.
REQ-011 SHALL have these ports: op output 4, ALU operation.
REQ-012 SHALL have these ports: wren output 1, data-memory write enable.
REQ-013 SHALL have these ports: regwen output 1, register-file write enable.
REQ-014 SHALL have these ports: wbsel output 2, writeback source: 00 = memory, 01 = ALU, 10 = PC+4.
REQ-015 SHALL have these ports: rwsel output 3, memory access size/sign; always equals instr[14:12].
REQ-016 SHALL have these ports: ill output 1, combinational unsupported-instruction flag.
REQ-017 SHALL have these ports: illflag output 1, registered sticky copy of ill.

Function
REQ-018 All outputs except illflag SHALL be purely combinational from instr, breq and brlt; zero latency, independent of clk and rst.
REQ-019 Decode SHALL use instr[6:2] as opcode, instr[14:12] as funct3 (f3) and instr[30] as b30; instr[1:0], instr[31] and all other bits SHALL be ignored.
REQ-020 brun SHALL equal f3[1] for every opcode.
REQ-021 R-type (opcode 01100): immsel=00000, asel=0, bsel=0, op={b30,f3}, wren=0, regwen=1, wbsel=01, pcsel=0.
REQ-022 I-ALU (00100): immsel=00001, asel=0, bsel=1, op={b30 if f3==101 else 0, f3}, wren=0, regwen=1, wbsel=01, pcsel=0.
REQ-023 Load (00000): immsel=00001, asel=0, bsel=1, op=0000, wren=0, regwen=1, wbsel=00, pcsel=0.
REQ-024 Store (01000): immsel=00010, asel=0, bsel=1, op=0000, wren=1, regwen=0, wbsel=00, pcsel=0.
REQ-025 Branch (11000): immsel=00100, asel=1, bsel=1, op=0000, wren=0, regwen=0, wbsel=00.
REQ-026 Branch pcsel by f3: 000 breq; 001 ~breq; 100 and 110 brlt; 101 and 111 ~brlt; 010 and 011 0.
REQ-027 JAL (11011): pcsel=1, immsel=10000, asel=1, bsel=1, op=0000, wren=0, regwen=1, wbsel=10.
REQ-028 JALR (11001): pcsel=1, immsel=00001, asel=0, bsel=1, op=0000, wren=0, regwen=1, wbsel=10; f3 ignored.
REQ-029 LUI (01101): pcsel=0, immsel=01000, asel=0, bsel=1, op=1001 (pass B), wren=0, regwen=1, wbsel=01.
REQ-030 AUIPC (00101): pcsel=0, immsel=01000, asel=1, bsel=1, op=0000, wren=0, regwen=1, wbsel=01.
REQ-031 ALU op encodings SHALL be: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1001 pass B.
REQ-032 ill SHALL be 1 for any of:
- opcode not listed above;
- R-type with b30=1 and f3 not 000 or 101;
- I-ALU with f3=001 and b30=1;
- load with f3 of 011, 110 or 111;
- store with f3 above 010;
- branch with f3 of 010 or 011.
REQ-033 When ill=1, outputs SHALL be pcsel=0, regwen=0, wren=0, immsel=00000, asel=0, bsel=0, op=0000, wbsel=00, with rwsel=f3 and brun=f3[1] still applied.

Reset
REQ-034 rst=1 SHALL clear illflag to 0 immediately and asynchronously; no other output is affected by rst.
REQ-035 With rst=0, illflag SHALL set to 1 on any rising clk edge where ill=1, and SHALL hold 1 until rst.

Verification
REQ-036 instr=0x40000033 (sub) -> op=1000, regwen=1, wbsel=01, asel=0, bsel=0, pcsel=0, ill=0.
REQ-037 instr=0x40005013 (srai) -> immsel=00001, bsel=1, op=1101; instr=0x40001013 -> ill=1, regwen=0.
REQ-038 instr=0x00005003 (lhu) -> rwsel=101, wbsel=00, regwen=1; instr=0x00002023 (sw) -> wren=1, regwen=0, immsel=00010.
REQ-039 Branch sweep: bgeu (f3=111) with brlt=0 -> pcsel=1, brun=1; with brlt=1 -> pcsel=0; bne with breq=1 -> pcsel=0.
REQ-040 instr=0x0000006F (jal) -> pcsel=1, immsel=10000, wbsel=10; instr=0x00000037 (lui) -> op=1001, immsel=01000.
REQ-041 Illegal opcode 0x0000007F clocked once -> illflag=1; it holds after legal instructions; asserting rst mid-cycle -> illflag=0 before the next clk edge.
